// File: rtl/lbus_mac_core.sv
// lbus_mac_core
//   Modular multiply-accumulate core behind the local-bus interface.
//   b is latched on blk_krdy; a run starts on blk_drdy and captures NWORDS
//   words of a on consecutive edges. Each word gives r_i = (a_i*b) mod Q,
//   and acc accumulates the r_i mod Q. {r_last, acc} is published on
//   blk_dout with a one-cycle blk_dvld pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   a         streamed operand word (24 bits)
//   b         key operand, sampled on blk_krdy (24 bits)
//   blk_krdy  latch b
//   blk_drdy  start a run (ignored while busy)
//   blk_rstn  synchronous active-low soft reset, aborts any run
//   blk_dout  {80'h0, r_last, acc}, each zero-extended from 23 bits
//   blk_kvld  one-cycle pulse after b is latched
//   blk_dvld  one-cycle pulse when blk_dout is updated
//   busy      high from run start through the blk_dvld cycle
module lbus_mac_core #(
  parameter int unsigned NWORDS  = 6,
  parameter int unsigned Q       = 8380417,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [23:0]  a,
  input  logic [23:0]  b,
  input  logic         blk_krdy,
  input  logic         blk_drdy,
  input  logic         blk_rstn,
  output logic [127:0] blk_dout,
  output logic         blk_kvld,
  output logic         blk_dvld,
  output logic         busy
);

  localparam int unsigned CW = $clog2(NWORDS + MUL_LAT + 2);

  typedef enum logic [1:0] {IDLE, CAPT, DRAIN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            start, cap_en, fire;

  logic [23:0]     b_reg, b_run;
  logic [23:0]     a_cap;
  logic            cap_vld;
  logic [47:0]     prod;
  logic [22:0]     red0;
  logic [22:0]     r_pipe [MUL_LAT];
  logic [MUL_LAT-1:0] vld_pipe;
  logic [22:0]     r_out;
  logic            r_vld;
  logic [22:0]     acc, acc_next;
  logic [23:0]     acc_sum;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= IDLE;
    else if (!blk_rstn) state <= IDLE;
    else                state <= state_next;
  end

  // cnt counts edges since the start edge; capture ends when the last
  // word is taken, DONE is entered on the edge of the final acc update.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    cap_en     = 1'b0;
    fire       = 1'b0;
    unique case (state)
      IDLE: begin
        if (blk_drdy && !busy) begin
          start      = 1'b1;
          state_next = CAPT;
        end
      end
      CAPT: begin
        cap_en = 1'b1;
        if (cnt == CW'(NWORDS - 1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (cnt == CW'(NWORDS + MUL_LAT)) state_next = DONE;
      end
      DONE: begin
        fire       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- arithmetic ----------------
  // Reduction happens before the first pipeline register; the remaining
  // MUL_LAT-1 registers only delay the reduced product.
  assign prod  = 48'(a_cap) * 48'(b_run);
  assign red0  = 23'(prod % 48'(Q));
  assign r_out = r_pipe[MUL_LAT-1];
  assign r_vld = vld_pipe[MUL_LAT-1];

  assign acc_sum  = {1'b0, acc} + {1'b0, r_out};
  assign acc_next = (acc_sum >= 24'(Q)) ? 23'(acc_sum - 24'(Q)) : acc_sum[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      b_reg    <= '0;
      b_run    <= '0;
      a_cap    <= '0;
      cap_vld  <= 1'b0;
      vld_pipe <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) r_pipe[k] <= '0;
      acc      <= '0;
      blk_dout <= '0;
      blk_kvld <= 1'b0;
      blk_dvld <= 1'b0;
      busy     <= 1'b0;
    end else if (!blk_rstn) begin
      cnt      <= '0;
      b_reg    <= '0;
      b_run    <= '0;
      a_cap    <= '0;
      cap_vld  <= 1'b0;
      vld_pipe <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) r_pipe[k] <= '0;
      acc      <= '0;
      blk_dout <= '0;
      blk_kvld <= 1'b0;
      blk_dvld <= 1'b0;
      busy     <= 1'b0;
    end else begin
      blk_kvld <= blk_krdy;
      if (blk_krdy) b_reg <= b;

      if (start) begin
        // A key arriving on the start edge is the one this run uses.
        b_run <= blk_krdy ? b : b_reg;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == CAPT || state == DRAIN) begin
        cnt <= cnt + 1'b1;
      end

      cap_vld <= cap_en;
      if (cap_en) a_cap <= a;

      vld_pipe[0] <= cap_vld;
      r_pipe[0]   <= red0;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        r_pipe[k]   <= r_pipe[k-1];
      end

      if (start)      acc <= '0;
      else if (r_vld) acc <= acc_next;

      blk_dvld <= fire;
      if (fire) blk_dout <= {80'h0, 1'b0, r_out, 1'b0, acc};

      if (blk_dvld) busy <= 1'b0;
    end
  end

endmodule

// File: doc/lbus_mac_core.md
Name: lbus_mac_core

Overview:
- Cryptographic core directly downstream of the local-bus interface.
- Latches operand b on blk_krdy, then captures the six 24-bit words streamed on a after blk_drdy.
- Computes each r_i = (a_i*b) mod Q and the running sum acc = Σ r_i mod Q.
- Returns {r5, acc} on blk_dout with a one-cycle blk_dvld pulse; this is the SCA target (one modular multiply per cycle).

Parameters:
- NWORDS, 6, number of a words per run (counter width ≥3 bits).
- Q, 8380417, modulus (23-bit).
- MUL_LAT, 2, registered stages from word capture to reduced product r_i (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a  in  24  streamed operand word, valid on the NWORDS edges following blk_drdy
- b  in  24  second operand, sampled on blk_krdy
- blk_krdy  in  1  key-ready pulse: latch b
- blk_drdy  in  1  data-ready pulse: start run
- blk_rstn  in  1  synchronous active-low soft reset (1-cycle pulse)
- blk_dout  out  128  result {80'h0, r5[23:0], acc[23:0]}, each value zero-extended from 23 bits
- blk_kvld  out  1  one-cycle pulse, b latched
- blk_dvld  out  1  one-cycle pulse, blk_dout updated
- busy  out  1  high from start until blk_dvld cycle inclusive

Behaviour:
- rst_n low (async): state=IDLE; b_reg, acc, counters, blk_dout=0; blk_kvld, blk_dvld, busy=0.
- blk_rstn low at an edge: same clearing as rst_n, synchronous, priority over all other inputs; aborts any run with no blk_dvld.
- Key load:
  - blk_krdy high at edge E → b_reg<=b, blk_kvld high in cycle after E.
  - Accepted in any state; a run in progress keeps the b_reg value captured at its start (snapshot b_run at start edge).
- States: IDLE → CAPT → DRAIN → DONE → IDLE.
- IDLE:
  - blk_drdy high at edge E0 → CAPT, cnt=0, b_run<=b_reg, acc<=0, busy<=1.
  - If blk_krdy and blk_drdy occur at the same edge, b_run takes the new b.
- CAPT: word i (i=0..NWORDS-1) sampled from a at edge E(i+1); cnt increments; after E(NWORDS) → DRAIN.
- Arithmetic:
  - a and b are full 24-bit unsigned (may be ≥Q); r_i = (a_i*b_run) mod Q ∈ [0,Q).
  - r_i is registered at E(i+1+MUL_LAT).
  - acc <= (acc + r_i) mod Q at E(i+2+MUL_LAT), using a single conditional subtract.
  - Throughput: one word per cycle, no stalls.
- DRAIN: waits until the last acc update at E(NWORDS+1+MUL_LAT) → DONE.
- DONE: at E(NWORDS+2+MUL_LAT), blk_dout <= {80'h0, r_(NWORDS-1), acc}; blk_dvld high the following cycle; busy falls with blk_dvld; → IDLE.
  - Default timing: dvld cycle follows E10.
- blk_drdy while busy: ignored, no restart, no queueing.
- blk_dout holds its last value until the next DONE or reset.

Test Plan:
- Reset, then blk_krdy with b=2, then blk_drdy with a=1,2,3,4,5,6 → blk_kvld one cycle after krdy edge; blk_dvld exactly one cycle after E10; blk_dout={80'h0, 24'd12, 24'd42}; busy high E0..dvld.
- b=8380416, all a=8380416 → every r_i=1; blk_dout={80'h0, 24'd1, 24'd6}.
- b=24'hFFFFFF, all a=24'hFFFFFF (both ≥Q) → r_i=163817; acc=982902; blk_dout={80'h0, 24'd163817, 24'd982902}.
- Start run, blk_krdy with new b mid-CAPT, extra blk_drdy at E3 → result uses old b; single blk_dvld; no second run.
- blk_rstn pulse at E4 mid-run → no blk_dvld; blk_dout=0; busy=0 next cycle; a fresh run afterwards gives the correct result with b_reg=0 (all results 0).
- rst_n asserted asynchronously mid-DRAIN → outputs clear immediately without a clock edge.
